// File: rtl/instr_buffer_if.sv
// rtl/instr_buffer_if.sv - push/read/accept bundle between fetch, instr_buffer and dispatch
// Ports (slave = buffer side):
//   push_valid_i/push_pc_i/push_instr_i/push_excp_i/push_excp_num_i : 2-lane push from fetch
//   push_ready_o                                                     : buffer can take a 2-lane push
//   out_valid_o/out_pc_o/out_instr_o/out_excp_o/out_excp_num_o       : 2 oldest entries, program order
//   accept_i                                                         : per-lane consume mask from dispatch
interface instr_buffer_if;
    logic [1:0]       push_valid_i;
    logic [1:0][31:0] push_pc_i;
    logic [1:0][31:0] push_instr_i;
    logic [1:0]       push_excp_i;
    logic [1:0][3:0]  push_excp_num_i;
    logic             push_ready_o;
    logic [1:0]       out_valid_o;
    logic [1:0][31:0] out_pc_o;
    logic [1:0][31:0] out_instr_o;
    logic [1:0]       out_excp_o;
    logic [1:0][3:0]  out_excp_num_o;
    logic [1:0]       accept_i;

    modport slave (
        input  push_valid_i, push_pc_i, push_instr_i, push_excp_i, push_excp_num_i, accept_i,
        output push_ready_o, out_valid_o, out_pc_o, out_instr_o, out_excp_o, out_excp_num_o
    );

    modport master (
        output push_valid_i, push_pc_i, push_instr_i, push_excp_i, push_excp_num_i, accept_i,
        input  push_ready_o, out_valid_o, out_pc_o, out_instr_o, out_excp_o, out_excp_num_o
    );
endinterface

// File: rtl/instr_buffer.sv
// rtl/instr_buffer.sv - 2-in/2-out circular instruction FIFO between fetch and decode/dispatch
// Ports:
//   clk, rst_n (asynchronous, active-low)
//   flush_i        : empty the buffer next cycle (priority over push/pop)
//   ib             : instr_buffer_if.slave push / read / accept bundle
//   count_o        : current occupancy
//   full_cycles_o  : cycles with push_ready_o=0 (IB_PERF_CNT_EN, else 0)
//   empty_cycles_o : cycles with count_o=0    (IB_PERF_CNT_EN, else 0)
// Optional feature macro: IB_PERF_CNT_EN enables the saturating perf counters.
module instr_buffer #(
    parameter int DEPTH       = 8,
    parameter int WRITE_WIDTH = 2,
    parameter int READ_WIDTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    instr_buffer_if.slave          ib,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [31:0]            full_cycles_o,
    output logic [31:0]            empty_cycles_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        excp;
        logic [3:0]  excp_num;
    } entry_t;

    entry_t         mem_q [DEPTH];
    entry_t         mem_d [DEPTH];
    logic [AW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;

    logic           push_ready;
    logic           push_fire;
    logic [1:0]     out_valid;
    logic [1:0]     pop_mask;
    logic [1:0]     push_n, pop_n;
    logic [AW-1:0]  wr_idx1;
    logic [AW-1:0]  rd_idx [2];

    always_comb begin
        // Ready looks only at registered count: a same-cycle pop earns no credit.
        push_ready = (count_q <= CW'(DEPTH - WRITE_WIDTH));
        for (int i = 0; i < READ_WIDTH; i++) begin
            out_valid[i] = (count_q > CW'(i));
            rd_idx[i]    = head_q + AW'(i);
        end

        // In-order retire: lane1 only leaves together with lane0.
        pop_mask[0] = ib.accept_i[0] & out_valid[0];
        pop_mask[1] = ib.accept_i[1] & out_valid[1] & pop_mask[0];
        pop_n       = {1'b0, pop_mask[0]} + {1'b0, pop_mask[1]};

        push_fire = push_ready & (|ib.push_valid_i);
        push_n    = push_fire ? ({1'b0, ib.push_valid_i[0]} + {1'b0, ib.push_valid_i[1]}) : 2'd0;
        // Compaction: lane1 lands at tail when lane0 is empty, else at tail+1.
        wr_idx1   = tail_q + AW'(ib.push_valid_i[0]);

        mem_d   = mem_q;
        head_d  = head_q + AW'(pop_n);
        tail_d  = tail_q + AW'(push_n);
        count_d = count_q + CW'(push_n) - CW'(pop_n);

        if (push_fire && !flush_i) begin
            if (ib.push_valid_i[0])
                mem_d[tail_q] = '{pc: ib.push_pc_i[0], instr: ib.push_instr_i[0],
                                  excp: ib.push_excp_i[0], excp_num: ib.push_excp_num_i[0]};
            if (ib.push_valid_i[1])
                mem_d[wr_idx1] = '{pc: ib.push_pc_i[1], instr: ib.push_instr_i[1],
                                   excp: ib.push_excp_i[1], excp_num: ib.push_excp_num_i[1]};
        end

        // Storage is left as-is on flush; only the pointers are reset.
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        ib.push_ready_o = push_ready;
        ib.out_valid_o  = out_valid;
        for (int i = 0; i < 2; i++) begin
            ib.out_pc_o[i]       = mem_q[rd_idx[i]].pc;
            ib.out_instr_o[i]    = mem_q[rd_idx[i]].instr;
            ib.out_excp_o[i]     = mem_q[rd_idx[i]].excp;
            ib.out_excp_num_o[i] = mem_q[rd_idx[i]].excp_num;
        end
    end

    assign count_o = count_q;

`ifdef IB_PERF_CNT_EN
    logic [31:0] full_cnt_q, full_cnt_d, empty_cnt_q, empty_cnt_d;

    always_comb begin
        full_cnt_d  = full_cnt_q;
        empty_cnt_d = empty_cnt_q;
        if (!push_ready && (full_cnt_q != '1))     full_cnt_d  = full_cnt_q + 32'd1;
        if ((count_q == '0) && (empty_cnt_q != '1)) empty_cnt_d = empty_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_cnt_q  <= '0;
            empty_cnt_q <= '0;
        end else begin
            full_cnt_q  <= full_cnt_d;
            empty_cnt_q <= empty_cnt_d;
        end
    end

    assign full_cycles_o  = full_cnt_q;
    assign empty_cycles_o = empty_cnt_q;
`else
    assign full_cycles_o  = '0;
    assign empty_cycles_o = '0;
`endif

    count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        (int'(count_q) + int'(push_n) - int'(pop_n) >= 0) &&
        (int'(count_q) + int'(push_n) - int'(pop_n) <= DEPTH));
endmodule

// File: tb/tb_instr_buffer.sv
// tb/tb_instr_buffer.sv - self-checking bench for instr_buffer against a queue reference model
module tb_instr_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic [3:0]  count_o;
    logic [31:0] full_cycles_o, empty_cycles_o;

    int checks = 0;
    int failures = 0;

`ifdef IB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    instr_buffer_if ibus ();

    instr_buffer #(.DEPTH(8), .WRITE_WIDTH(2), .READ_WIDTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .ib             (ibus),
        .count_o        (count_o),
        .full_cycles_o  (full_cycles_o),
        .empty_cycles_o (empty_cycles_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        excp;
        logic [3:0]  num;
    } ent_t;

    ent_t q[$];
    int   full_m, empty_m;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        full_m = 0;
        empty_m = 0;
    endtask

    // One clock: apply stimulus at negedge, advance the queue model, return at next negedge.
    task automatic drive(input logic [1:0] pv, input logic [1:0] acc, input logic fl);
        bit   ready;
        int   n;
        ent_t e;
        for (int l = 0; l < 2; l++) begin
            ibus.push_pc_i[l]       = $urandom;
            ibus.push_instr_i[l]    = $urandom;
            ibus.push_excp_i[l]     = 1'($urandom_range(0, 1));
            ibus.push_excp_num_i[l] = 4'($urandom_range(0, 15));
        end
        ibus.push_valid_i = pv;
        ibus.accept_i     = acc;
        flush_i           = fl;

        ready = (8 - q.size()) >= 2;
        if (!ready) full_m++;
        if (q.size() == 0) empty_m++;
        if (fl) begin
            q.delete();
        end else begin
            n = 0;
            if (acc[0] && q.size() > 0) begin
                n = 1;
                if (acc[1] && q.size() > 1) n = 2;
            end
            repeat (n) void'(q.pop_front());
            if (ready) begin
                for (int l = 0; l < 2; l++) begin
                    if (pv[l]) begin
                        e.pc = ibus.push_pc_i[l];
                        e.instr = ibus.push_instr_i[l];
                        e.excp = ibus.push_excp_i[l];
                        e.num = ibus.push_excp_num_i[l];
                        q.push_back(e);
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        ibus.push_valid_i = 2'b00;
        ibus.accept_i     = 2'b00;
        flush_i           = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (ibus.push_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ibus.push_ready_o); end
        checks++; if (ibus.out_valid_o !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", ibus.out_valid_o); end
        checks++; if ({ibus.out_pc_o, ibus.out_instr_o, ibus.out_excp_o, ibus.out_excp_num_o} !== '0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", {ibus.out_pc_o, ibus.out_instr_o});
        end
        checks++; if ({full_cycles_o, empty_cycles_o} !== 64'd0) begin
            failures++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", full_cycles_o, empty_cycles_o);
        end
        repeat (3) drive(2'b00, 2'b00, 1'b0);
        checks++; if (empty_cycles_o !== (PERF ? 32'd3 : 32'd0)) begin
            failures++; $display("FAIL idle_empty_cycles got=%0d exp=%0d", empty_cycles_o, PERF ? 3 : 0);
        end
    endtask

    task automatic test_fill();
        logic [31:0] pc0, pc1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 2'b00, 1'b0);
            if (k == 0) begin pc0 = q[0].pc; pc1 = q[1].pc; end
            checks++; if (count_o !== 4'(2 * (k + 1))) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", count_o, 2 * (k + 1)); end
            checks++; if (ibus.push_ready_o !== (k < 3)) begin failures++; $display("FAIL fill_ready got=%b exp=%b", ibus.push_ready_o, k < 3); end
        end
        drive(2'b11, 2'b00, 1'b0);
        checks++; if (count_o !== 4'd8) begin failures++; $display("FAIL fill_overpush got=%0d exp=8", count_o); end
        checks++; if (ibus.out_pc_o[0] !== pc0 || ibus.out_pc_o[1] !== pc1) begin
            failures++; $display("FAIL fill_head_pc got=%h/%h exp=%h/%h", ibus.out_pc_o[0], ibus.out_pc_o[1], pc0, pc1);
        end
        checks++; if (full_cycles_o !== (PERF ? 32'd1 : 32'd0)) begin
            failures++; $display("FAIL fill_full_cycles got=%0d exp=%0d", full_cycles_o, PERF ? 1 : 0);
        end
    endtask

    // Continues from the full buffer left by test_fill.
    task automatic test_push_blocked();
        logic [31:0] e0, e1;
        drive(2'b00, 2'b01, 1'b0);
        checks++; if (count_o !== 4'd7 || ibus.push_ready_o !== 1'b0) begin
            failures++; $display("FAIL c7_state got=%0d/%b exp=7/0", count_o, ibus.push_ready_o);
        end
        e0 = q[1].pc;
        drive(2'b11, 2'b01, 1'b0);
        checks++; if (count_o !== 4'd6) begin failures++; $display("FAIL c7_push_ignored got=%0d exp=6", count_o); end
        checks++; if (ibus.out_pc_o[0] !== e0) begin failures++; $display("FAIL c7_head got=%h exp=%h", ibus.out_pc_o[0], e0); end
        e0 = q[2].pc; e1 = q[3].pc;
        drive(2'b11, 2'b11, 1'b0);
        checks++; if (count_o !== 4'd6) begin failures++; $display("FAIL c6_pushpop got=%0d exp=6", count_o); end
        checks++; if (ibus.out_pc_o[0] !== e0 || ibus.out_pc_o[1] !== e1) begin
            failures++; $display("FAIL c6_order got=%h/%h exp=%h/%h", ibus.out_pc_o[0], ibus.out_pc_o[1], e0, e1);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e0, e1, e2;
        do_reset();
        repeat (4) drive(2'b11, 2'b00, 1'b0);
        repeat (3) drive(2'b00, 2'b11, 1'b0);
        drive(2'b00, 2'b01, 1'b0);
        drive(2'b11, 2'b00, 1'b0);
        checks++; if (count_o !== 4'd3) begin failures++; $display("FAIL wrap_count3 got=%0d exp=3", count_o); end
        e0 = q[0].pc; e1 = q[1].pc; e2 = q[2].pc;
        checks++; if (ibus.out_pc_o[0] !== e0 || ibus.out_pc_o[1] !== e1) begin
            failures++; $display("FAIL wrap_read got=%h/%h exp=%h/%h", ibus.out_pc_o[0], ibus.out_pc_o[1], e0, e1);
        end
        drive(2'b00, 2'b11, 1'b0);
        checks++; if (count_o !== 4'd1 || ibus.out_pc_o[0] !== e2) begin
            failures++; $display("FAIL wrap_pop got=%0d/%h exp=1/%h", count_o, ibus.out_pc_o[0], e2);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(2'b11, 2'b00, 1'b0);
        drive(2'b00, 2'b11, 1'b0);
        drive(2'b10, 2'b00, 1'b0);
        checks++; if (count_o !== 4'd1 || ibus.out_pc_o[0] !== q[0].pc || ibus.out_instr_o[0] !== q[0].instr) begin
            failures++; $display("FAIL lane1_compact got=%0d/%h exp=1/%h", count_o, ibus.out_pc_o[0], q[0].pc);
        end
        drive(2'b11, 2'b00, 1'b0);
        drive(2'b11, 2'b00, 1'b0);
        checks++; if (count_o !== 4'd5) begin failures++; $display("FAIL flush_pre got=%0d exp=5", count_o); end
        drive(2'b11, 2'b11, 1'b1);
        checks++; if (count_o !== 4'd0 || ibus.out_valid_o !== 2'b00 || ibus.push_ready_o !== 1'b1) begin
            failures++; $display("FAIL flush_state got=%0d/%b/%b exp=0/00/1", count_o, ibus.out_valid_o, ibus.push_ready_o);
        end
        drive(2'b01, 2'b00, 1'b0);
        checks++; if (count_o !== 4'd1 || ibus.out_pc_o[0] !== q[0].pc) begin
            failures++; $display("FAIL flush_after got=%0d/%h exp=1/%h", count_o, ibus.out_pc_o[0], q[0].pc);
        end
    endtask

    task automatic test_accept_mask();
        logic [31:0] e0;
        do_reset();
        drive(2'b11, 2'b00, 1'b0);
        e0 = q[0].pc;
        drive(2'b00, 2'b10, 1'b0);
        checks++; if (count_o !== 4'd2 || ibus.out_pc_o[0] !== e0) begin
            failures++; $display("FAIL accept10 got=%0d/%h exp=2/%h", count_o, ibus.out_pc_o[0], e0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(2'b11, 2'b00, 1'b0);
        drive(2'b11, 2'b00, 1'b0);
        rst_n = 1'b0;
        #2;
        checks++; if (count_o !== 4'd0 || ibus.out_valid_o !== 2'b00 || ibus.push_ready_o !== 1'b1) begin
            failures++; $display("FAIL async_reset got=%0d/%b/%b exp=0/00/1", count_o, ibus.out_valid_o, ibus.push_ready_o);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [1:0] pv, acc;
        logic       fl;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            pv  = 2'($urandom_range(0, 3));
            acc = ((c / 50) % 2 == 0) ? 2'($urandom_range(0, 3) & $urandom_range(0, 3)) : 2'($urandom_range(0, 3));
            fl  = ($urandom_range(0, 40) == 0);
            drive(pv, acc, fl);
            checks++; if (count_o !== 4'(q.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, count_o, q.size()); end
            checks++; if (ibus.push_ready_o !== (q.size() <= 6)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, ibus.push_ready_o, q.size() <= 6); end
            checks++; if (ibus.out_valid_o !== {q.size() > 1, q.size() > 0}) begin
                failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, ibus.out_valid_o, {q.size() > 1, q.size() > 0});
            end
            for (int i = 0; i < 2; i++) begin
                if (q.size() > i) begin
                    checks++;
                    if (ibus.out_pc_o[i] !== q[i].pc || ibus.out_instr_o[i] !== q[i].instr ||
                        ibus.out_excp_o[i] !== q[i].excp || ibus.out_excp_num_o[i] !== q[i].num) begin
                        failures++;
                        $display("FAIL rnd_data cyc=%0d lane=%0d got=%h/%h/%b/%h exp=%h/%h/%b/%h", c, i,
                                 ibus.out_pc_o[i], ibus.out_instr_o[i], ibus.out_excp_o[i], ibus.out_excp_num_o[i],
                                 q[i].pc, q[i].instr, q[i].excp, q[i].num);
                    end
                end
            end
            checks++; if ($isunknown({ibus.out_pc_o, ibus.out_instr_o, ibus.out_excp_o, ibus.out_excp_num_o})) begin
                failures++; $display("FAIL rnd_xfree cyc=%0d got=%h exp=known", c, {ibus.out_pc_o, ibus.out_instr_o});
            end
            checks++; if (full_cycles_o !== (PERF ? 32'(full_m) : 32'd0) || empty_cycles_o !== (PERF ? 32'(empty_m) : 32'd0)) begin
                failures++; $display("FAIL rnd_perf cyc=%0d got=%0d/%0d exp=%0d/%0d", c, full_cycles_o, empty_cycles_o,
                                     PERF ? full_m : 0, PERF ? empty_m : 0);
            end
        end
    endtask

    initial begin
        ibus.push_valid_i    = 2'b00;
        ibus.push_pc_i       = '0;
        ibus.push_instr_i    = '0;
        ibus.push_excp_i     = 2'b00;
        ibus.push_excp_num_i = '0;
        ibus.accept_i        = 2'b00;
        test_reset();
        test_fill();
        test_push_blocked();
        test_wrap();
        test_flush();
        test_accept_mask();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_buffer.md
Name: instr_buffer

Overview:
- Circular FIFO between the fetch frontend and the decode/dispatch path.
- Absorbs up to 2 fetched instructions per cycle.
- Presents the 2 oldest entries to decode in program order.
- Retires entries according to the per-lane accept mask from dispatch (ib_accept_o → accept_i).
- Flush from ctrl empties the buffer in one cycle.

Parameters:
- DEPTH, 8, number of entries; power of two, ≥4.
- WRITE_WIDTH, 2, push lanes (fixed at 2 in this revision).
- READ_WIDTH, 2, pop lanes (fixed at 2 in this revision).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  discard all entries
- push_valid_i  in  2  per-lane instruction valid from frontend
- push_pc_i  in  2x32  lane PCs
- push_instr_i  in  2x32  lane instruction words
- push_excp_i  in  2  lane fetch-exception flag
- push_excp_num_i  in  2x4  lane exception code
- push_ready_o  out  1  buffer can take a 2-lane push this cycle
- out_valid_o  out  2  entry head+i present
- out_pc_o  out  2x32  PC of head+i
- out_instr_o  out  2x32  instruction of head+i
- out_excp_o  out  2  exception flag of head+i
- out_excp_num_o  out  2x4  exception code of head+i
- accept_i  in  2  per-lane consume mask from dispatch
- count_o  out  $clog2(DEPTH)+1  current occupancy
- full_cycles_o  out  32  perf: cycles with push_ready_o=0
- empty_cycles_o  out  32  perf: cycles with count_o=0

Behaviour:
- State: head and tail pointers ($clog2(DEPTH) bits, natural wrap); count ($clog2(DEPTH)+1 bits); storage array.
- Reset: head=tail=count=0 and storage zeroed.
  - Reset values: push_ready_o=1, out_valid_o=00, all out data 0, perf counters 0.
  - Reset mid-operation discards everything immediately (asynchronous).
- push_ready_o = (DEPTH − count ≥ 2). Computed from registered count only; same-cycle pops give no credit.
- Push fires when push_ready_o & |push_valid_i.
  - Valid lanes are compacted: lane0 writes at tail if valid, and the next valid lane writes at the next slot.
  - Pattern 10 writes lane1 at tail.
  - tail advances by popcount(push_valid_i).
  - When push_ready_o=0 the push is ignored; the frontend holds its data.
- Read side is combinational from registered state:
  - out_valid_o[i] = (count > i).
  - out_*[i] = storage[head+i mod DEPTH].
  - Data on an invalid lane is don't-care but must be X-free.
- Pop: effective mask pm = accept_i & out_valid_o, with pm[1] honoured only if pm[0]=1 (in-order retire).
  - Mask 10 retires nothing.
  - head advances by popcount(pm).
- Simultaneous push and pop in one cycle: count_next = count + pushed − popped. The write to tail and the read at head never conflict, because ready guarantees 2 free slots.
- Flush has priority over push and pop: next cycle head=tail=count=0 and any same-cycle push/pop is discarded. Storage is not cleared.
- Latency: an instruction pushed in cycle N appears on out_valid_o in cycle N+1 (no bypass when empty).
- Wrap-around: pointers wrap modulo DEPTH. A 2-lane push or pop straddling index DEPTH−1→0 is legal.
- count never exceeds DEPTH and never underflows. Violations are design errors, flagged by assertion in simulation.

Optional Feature:
- Macro IB_PERF_CNT_EN.
- Defined:
  - full_cycles_o increments every non-reset cycle with push_ready_o=0.
  - empty_cycles_o increments every non-reset cycle with count=0.
  - Both are 32-bit saturating, cleared only by reset (not by flush).
- Undefined: both ports are tied to 0 and no counter flops are synthesised.

Test Plan:
- Reset, then push 11 ×4 cycles with accept_i=00 (DEPTH=8) → count_o 2,4,6,8; push_ready_o drops to 0 when count=7 or 8 (here after reaching 8, and already at 6→ready=1, 8→ready=0); a 5th push is ignored; out_pc_o shows the first two PCs.
- count=7, push 11, accept 01 same cycle → push ignored (ready=0), count becomes 6, head advances by 1.
- count=6, push 11 with accept 11 → count stays 6; FIFO order preserved across the tail wrap from index 7→0.
- head at index 7, count=3, accept 11 → out_pc_o shows entries 7 then 0; after the pop, head=1 and count=1.
- count=5, flush_i=1 with push 11 and accept 11 → next cycle count=0, out_valid_o=00, push_ready_o=1.
- accept_i=10 with count=2 → nothing retired, count stays 2. With IB_PERF_CNT_EN, 3 idle cycles after reset give empty_cycles_o=3.
